// File: rtl/mem_cnt_pkg.sv
// ============================================================================
// Module  : mem_cnt_pkg
// Brief   : Shared types for the counter-table read-modify-write controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_cnt_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OP_UPD = 1'b0,
    OP_RD  = 1'b1
  } op_t;

  // The pointer names the stream that wins the next contended cycle.
  typedef enum logic [0:0] {
    PRIO_UPD = 1'b0,
    PRIO_RD  = 1'b1
  } prio_t;

endpackage

`default_nettype wire

// File: rtl/mem_1rw1rw_array.sv
// ============================================================================
// Module  : mem_1rw1rw_array
// Brief   : Dual-port RAM, each port read or write, synchronous read data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_1rw1rw_array #(
  parameter int    WIDTH_ADDR          = 8,
  parameter int    WIDTH_DATA          = 32,
  parameter string READ_DURING_WRITE_A = "new",
  parameter string DOUT_REG_A          = "false"
) (
  input  logic                  clka,
  input  logic                  rena,
  input  logic                  wena,
  input  logic [WIDTH_ADDR-1:0] addra,
  input  logic [WIDTH_DATA-1:0] dina,
  output logic [WIDTH_DATA-1:0] douta,
  input  logic                  clkb,
  input  logic                  renb,
  input  logic                  wenb,
  input  logic [WIDTH_ADDR-1:0] addrb,
  input  logic [WIDTH_DATA-1:0] dinb,
  output logic [WIDTH_DATA-1:0] doutb
);

  localparam int c_DEPTH   = 1 << WIDTH_ADDR;
  localparam bit c_RDW_NEW = (READ_DURING_WRITE_A == "new");

  logic [WIDTH_DATA-1:0] r_mem [c_DEPTH];
  logic [WIDTH_DATA-1:0] r_rda;
  logic [WIDTH_DATA-1:0] r_rdb;

  // One process owns the array, so clkb must be tied to clka; port B wins a same-address collision.
  always_ff @(posedge clka) begin
    if (wena) r_mem[addra] <= dina;
    if (wenb) r_mem[addrb] <= dinb;
  end

  always_ff @(posedge clka) begin
    if (rena) r_rda <= (wena && c_RDW_NEW) ? dina : r_mem[addra];
  end

  if (DOUT_REG_A == "true") begin : g_douta_reg
    logic [WIDTH_DATA-1:0] r_douta;
    always_ff @(posedge clka) r_douta <= r_rda;
    assign douta = r_douta;
  end else begin : g_douta_raw
    assign douta = r_rda;
  end

  always_ff @(posedge clkb) begin
    if (renb) r_rdb <= r_mem[addrb];
  end

  assign doutb = r_rdb;

endmodule

`default_nettype wire

// File: rtl/mem_cnt_rmw_ctrl.sv
// ============================================================================
// Module  : mem_cnt_rmw_ctrl
// Brief   : Zero-initialised counter table with increment and read/clear RMW.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_cnt_rmw_ctrl
  import mem_cnt_pkg::*;
#(
  parameter int WIDTH_ADDR  = 8,
  parameter int WIDTH_DATA  = 32,
  parameter int WIDTH_DELTA = 16,
  parameter int SATURATE    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   upd_vld,
  output logic                   upd_rdy,
  input  logic [WIDTH_ADDR-1:0]  upd_addr,
  input  logic [WIDTH_DELTA-1:0] upd_delta,
  input  logic                   rd_vld,
  output logic                   rd_rdy,
  input  logic [WIDTH_ADDR-1:0]  rd_addr,
  input  logic                   rd_clr,
  output logic                   rsp_vld,
  output logic [WIDTH_DATA-1:0]  rsp_data,
  output logic                   init_done,
  output logic                   sat_evt
);

  localparam int c_W_SUM = ((WIDTH_DELTA > WIDTH_DATA) ? WIDTH_DELTA : WIDTH_DATA) + 1;
  localparam logic [WIDTH_ADDR-1:0] c_ADDR_LAST = '1;
  localparam bit c_SAT = (SATURATE != 0);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH_ADDR-1:0]  r_sweep;
  logic                   r_init_done;
  prio_t                  r_prio;
  logic                   w_run;
  logic                   w_init_wr;

  logic                   w_upd_rdy;
  logic                   w_rd_rdy;
  logic                   w_upd_acc;
  logic                   w_rd_acc;
  logic                   w_acc;
  logic [WIDTH_ADDR-1:0]  w_s0_addr;

  logic                   r_s1_vld;
  op_t                    r_s1_op;
  logic [WIDTH_ADDR-1:0]  r_s1_addr;
  logic [WIDTH_DELTA-1:0] r_s1_delta;
  logic                   r_s1_clr;
  logic                   r_fwd_hit;
  logic [WIDTH_DATA-1:0]  r_fwd_data;

  logic [WIDTH_DATA-1:0]  w_douta;
  logic [WIDTH_DATA-1:0]  w_doutb;
  logic [WIDTH_DATA-1:0]  w_base;
  logic [c_W_SUM-1:0]     w_sum;
  logic                   w_ovf;
  logic                   w_sat_hit;
  logic [WIDTH_DATA-1:0]  w_upd_val;
  logic                   w_s1_wr;
  logic [WIDTH_DATA-1:0]  w_s1_wdata;

  logic                   w_wenb;
  logic [WIDTH_ADDR-1:0]  w_addrb;
  logic [WIDTH_DATA-1:0]  w_dinb;

  logic                   r_rsp_vld;
  logic [WIDTH_DATA-1:0]  r_rsp_data;
  logic                   w_unused;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_sweep == c_ADDR_LAST) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    w_run     = 1'b0;
    w_init_wr = 1'b0;
    case (r_state)
      ST_INIT: w_init_wr = 1'b1;
      ST_RUN:  w_run     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sweep     <= '0;
      r_init_done <= 1'b0;
    end else begin
      if (w_init_wr) r_sweep <= r_sweep + 1'b1;
      if (w_state_nxt == ST_RUN) r_init_done <= 1'b1;
    end
  end

  assign w_upd_rdy = w_run & (!rd_vld  | (r_prio == PRIO_UPD));
  assign w_rd_rdy  = w_run & (!upd_vld | (r_prio == PRIO_RD));
  assign w_upd_acc = upd_vld & w_upd_rdy;
  assign w_rd_acc  = rd_vld & w_rd_rdy;
  assign w_acc     = w_upd_acc | w_rd_acc;
  assign w_s0_addr = w_upd_acc ? upd_addr : rd_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= PRIO_UPD;
    end else if (w_run && upd_vld && rd_vld) begin
      r_prio <= w_upd_acc ? PRIO_RD : PRIO_UPD;
    end
  end

  // The S1 write lands on the same edge that S0's read samples the RAM, so it is forwarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_op    <= OP_UPD;
      r_s1_addr  <= '0;
      r_s1_delta <= '0;
      r_s1_clr   <= 1'b0;
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_op    <= w_upd_acc ? OP_UPD : OP_RD;
        r_s1_addr  <= w_s0_addr;
        r_s1_delta <= upd_delta;
        r_s1_clr   <= w_rd_acc & rd_clr;
        r_fwd_hit  <= w_s1_wr & (r_s1_addr == w_s0_addr);
        r_fwd_data <= w_s1_wdata;
      end
    end
  end

  assign w_base     = r_fwd_hit ? r_fwd_data : w_douta;
  assign w_sum      = {{(c_W_SUM-WIDTH_DATA){1'b0}}, w_base}
                    + {{(c_W_SUM-WIDTH_DELTA){1'b0}}, r_s1_delta};
  assign w_ovf      = |w_sum[c_W_SUM-1:WIDTH_DATA];
  assign w_sat_hit  = c_SAT & w_ovf;
  assign w_upd_val  = w_sat_hit ? '1 : w_sum[WIDTH_DATA-1:0];
  assign w_s1_wr    = r_s1_vld & ((r_s1_op == OP_UPD) | r_s1_clr);
  assign w_s1_wdata = (r_s1_op == OP_UPD) ? w_upd_val : '0;

  always_comb begin
    w_wenb  = w_s1_wr;
    w_addrb = r_s1_addr;
    w_dinb  = w_s1_wdata;
    if (w_init_wr) begin
      w_wenb  = 1'b1;
      w_addrb = r_sweep;
      w_dinb  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_rsp_vld <= r_s1_vld & (r_s1_op == OP_RD);
      if (r_s1_vld && (r_s1_op == OP_RD)) r_rsp_data <= w_base;
    end
  end

  mem_1rw1rw_array #(
    .WIDTH_ADDR          (WIDTH_ADDR),
    .WIDTH_DATA          (WIDTH_DATA),
    .READ_DURING_WRITE_A ("new"),
    .DOUT_REG_A          ("false")
  ) u_ram (
    .clka  (clk),
    .rena  (w_acc),
    .wena  (1'b0),
    .addra (w_s0_addr),
    .dina  ('0),
    .douta (w_douta),
    .clkb  (clk),
    .renb  (1'b0),
    .wenb  (w_wenb),
    .addrb (w_addrb),
    .dinb  (w_dinb),
    .doutb (w_doutb)
  );

  assign w_unused = &{1'b0, w_doutb};

  assign upd_rdy   = w_upd_rdy;
  assign rd_rdy    = w_rd_rdy;
  assign rsp_vld   = r_rsp_vld;
  assign rsp_data  = r_rsp_data;
  assign init_done = r_init_done;
  assign sat_evt   = r_s1_vld & (r_s1_op == OP_UPD) & w_sat_hit;

endmodule

`default_nettype wire

// File: tb/tb_mem_cnt_rmw_ctrl.sv
// ============================================================================
// Module  : tb_mem_cnt_rmw_ctrl
// Brief   : Directed bench; a saturating and a wrapping instance share stimulus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_cnt_rmw_ctrl;

  logic       clk;
  logic       rst_n;
  logic       upd_vld;
  logic [3:0] upd_addr;
  logic [7:0] upd_delta;
  logic       rd_vld;
  logic [3:0] rd_addr;
  logic       rd_clr;

  logic       upd_rdy0, rd_rdy0, rsp_vld0, init_done0, sat_evt0;
  logic [7:0] rsp_data0;
  logic       upd_rdy1, rd_rdy1, rsp_vld1, init_done1, sat_evt1;
  logic [7:0] rsp_data1;

  int checks   = 0;
  int failures = 0;
  int n_sat0   = 0;
  int n_sat1   = 0;

  mem_cnt_rmw_ctrl #(
    .WIDTH_ADDR(4), .WIDTH_DATA(8), .WIDTH_DELTA(8), .SATURATE(1)
  ) u_dut_sat (
    .clk(clk), .rst_n(rst_n),
    .upd_vld(upd_vld), .upd_rdy(upd_rdy0), .upd_addr(upd_addr), .upd_delta(upd_delta),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy0), .rd_addr(rd_addr), .rd_clr(rd_clr),
    .rsp_vld(rsp_vld0), .rsp_data(rsp_data0), .init_done(init_done0), .sat_evt(sat_evt0)
  );

  mem_cnt_rmw_ctrl #(
    .WIDTH_ADDR(4), .WIDTH_DATA(8), .WIDTH_DELTA(8), .SATURATE(0)
  ) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .upd_vld(upd_vld), .upd_rdy(upd_rdy1), .upd_addr(upd_addr), .upd_delta(upd_delta),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy1), .rd_addr(rd_addr), .rd_clr(rd_clr),
    .rsp_vld(rsp_vld1), .rsp_data(rsp_data1), .init_done(init_done1), .sat_evt(sat_evt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sat_evt0) n_sat0++;
    if (sat_evt1) n_sat1++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic t_wait_init(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!init_done0 && n < 40);
    chk({tag, "_cycles"}, 32'(n), 32'd16);
    chk({tag, "_done_wrap"}, 32'(init_done1), 32'd1);
    @(negedge clk);
  endtask

  task automatic t_upd(input logic [3:0] addr, input logic [7:0] delta);
    upd_vld   = 1'b1;
    upd_addr  = addr;
    upd_delta = delta;
    #1;
    chk("upd_rdy", 32'(upd_rdy0), 32'd1);
    @(negedge clk);
    upd_vld = 1'b0;
  endtask

  task automatic t_read(input string tag, input logic [3:0] addr, input logic clr,
                        input logic [7:0] exp0, input logic [7:0] exp1);
    rd_vld  = 1'b1;
    rd_addr = addr;
    rd_clr  = clr;
    #1;
    chk({tag, "_rd_rdy"}, 32'(rd_rdy0), 32'd1);
    @(negedge clk);
    rd_vld = 1'b0;
    rd_clr = 1'b0;
    chk({tag, "_vld_early"}, 32'(rsp_vld0), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(rsp_vld0), 32'd1);
    chk({tag, "_data"}, 32'(rsp_data0), 32'(exp0));
    chk({tag, "_vld_wrap"}, 32'(rsp_vld1), 32'd1);
    chk({tag, "_data_wrap"}, 32'(rsp_data1), 32'(exp1));
    @(negedge clk);
    chk({tag, "_vld_pulse"}, 32'(rsp_vld0), 32'd0);
  endtask

  initial begin
    int s0, s1, nrsp;
    logic [7:0] rsp_a, rsp_b;
    rst_n = 1'b0; upd_vld = 1'b0; upd_addr = '0; upd_delta = '0;
    rd_vld = 1'b0; rd_addr = '0; rd_clr = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_upd_rdy", 32'(upd_rdy0), 32'd0);
    chk("rst_rd_rdy", 32'(rd_rdy0), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld0), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data0), 32'd0);
    chk("rst_init_done", 32'(init_done0), 32'd0);
    chk("rst_sat_evt", 32'(sat_evt0), 32'd0);

    rst_n = 1'b1;
    t_wait_init("init");
    t_read("init_rd5", 4'd5, 1'b0, 8'd0, 8'd0);

    t_upd(4'd3, 8'd5);
    t_read("single", 4'd3, 1'b0, 8'd5, 8'd5);

    t_upd(4'd7, 8'd1);
    t_upd(4'd7, 8'd2);
    t_upd(4'd7, 8'd3);
    t_read("hazard", 4'd7, 1'b0, 8'd6, 8'd6);
    repeat (2) @(negedge clk);
    t_read("hazard_ram", 4'd7, 1'b0, 8'd6, 8'd6);
    t_read("single_ram", 4'd3, 1'b0, 8'd5, 8'd5);

    #2;
    s0 = n_sat0;
    s1 = n_sat1;
    t_upd(4'd9, 8'd250);
    repeat (2) @(negedge clk);
    t_upd(4'd9, 8'd10);
    repeat (2) @(negedge clk);
    #2;
    chk("sat_pulses", 32'(n_sat0 - s0), 32'd1);
    chk("wrap_pulses", 32'(n_sat1 - s1), 32'd0);
    @(negedge clk);
    t_read("sat_val", 4'd9, 1'b0, 8'd255, 8'd4);

    nrsp = 0; rsp_a = '0; rsp_b = '0;
    upd_vld = 1'b1; upd_addr = 4'd2; upd_delta = 8'd1;
    rd_vld = 1'b1; rd_addr = 4'd2; rd_clr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        upd_vld = 1'b0; rd_vld = 1'b0; rd_clr = 1'b0;
      end
      #1;
      if (i < 4) begin
        chk("cont_upd_rdy", 32'(upd_rdy0), 32'((i % 2) == 0));
        chk("cont_rd_rdy", 32'(rd_rdy0), 32'((i % 2) == 1));
      end
      @(negedge clk);
      if (rsp_vld0) begin
        if (nrsp == 0) rsp_a = rsp_data0;
        else rsp_b = rsp_data0;
        nrsp++;
      end
    end
    chk("cont_nrsp", 32'(nrsp), 32'd2);
    chk("cont_rsp0", 32'(rsp_a), 32'd1);
    chk("cont_rsp1", 32'(rsp_b), 32'd1);
    t_read("cont_final", 4'd2, 1'b0, 8'd0, 8'd0);

    rd_vld = 1'b1; rd_addr = 4'd3; rd_clr = 1'b0;
    #1;
    chk("midrst_rd_rdy", 32'(rd_rdy0), 32'd1);
    @(negedge clk);
    rd_vld = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_vld", 32'(rsp_vld0), 32'd0);
    chk("midrst_rsp_vld_wrap", 32'(rsp_vld1), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data0), 32'd0);
    chk("midrst_init_done", 32'(init_done0), 32'd0);
    chk("midrst_upd_rdy", 32'(upd_rdy0), 32'd0);
    chk("midrst_rd_rdy_low", 32'(rd_rdy0), 32'd0);
    chk("midrst_sat_evt", 32'(sat_evt0), 32'd0);
    @(negedge clk);
    chk("midrst_rsp_vld_hold", 32'(rsp_vld0), 32'd0);
    rst_n = 1'b1;
    t_wait_init("reinit");
    t_read("reinit_rd3", 4'd3, 1'b0, 8'd0, 8'd0);
    t_read("reinit_rd7", 4'd7, 1'b0, 8'd0, 8'd0);
    t_read("reinit_rd9", 4'd9, 1'b0, 8'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
